attractor_finder: RTL
=====================

Name: attractor_finder

Overview:
Autonomous attractor search engine for the Boolean gene-network datapath. It replaces the externally stepped network loop and the separate fixed-point and cycle checkers with one block. From a seed state it iterates an external combinational network, keeps a parametrised history of past states, and reports one of three outcomes: fixed point, cycle (with its length), or timeout.

Parameters:
WIDTH, 8, number of genes (state vector width)
HIST_DEPTH, 8, states compared per step, including the current state; the longest detectable cycle is HIST_DEPTH (must be >= 1)
MAX_STEPS, 64, transition budget before timeout (must be >= 1)

Ports:
clk  input  1  system clock; all logic updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a search; honoured only when busy=0
seed  input  WIDTH  initial state, sampled on the edge that accepts start
next_state  input  WIDTH  combinational network output for cur_state, driven by an external network instance
cur_state  output  WIDTH  registered current state; drives the network input
busy  output  1  high while a search runs
done  output  1  level; high from search end until the next accepted start or reset
is_fixed  output  1  valid while done=1: fixed point found
is_cycle  output  1  valid while done=1: cycle of length >= 2 found
timeout  output  1  valid while done=1: budget exhausted with no detection
cycle_len  output  $clog2(HIST_DEPTH+1)  attractor period; 1 for a fixed point, 0 on timeout
steps  output  $clog2(MAX_STEPS+1)  transitions taken (cur_state updates) since seed

Behaviour:
- Reset (synchronous, active-high): state=IDLE; every output is 0, including cur_state; all history valid bits are cleared. Reset overrides start and aborts a search in progress within the same edge.
- State machine: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE with start=1: on that edge load cur_state<=seed, steps<=0, clear hist valid bits, clear done, is_fixed, is_cycle, timeout and cycle_len, set busy<=1, and go to RUN.
- RUN with start=1: start is ignored.
- History layout: entry 0 is cur_state and is always valid. Entries 1..HIST_DEPTH-1 form a shift register of earlier states, each with a valid bit.
- Each RUN cycle, compare next_state with every valid entry k.
  - The smallest matching k wins.
  - On a match: cycle_len<=k+1; is_fixed<=(k==0); is_cycle<=(k>0); done<=1; busy<=0; go to DONE. cur_state and steps hold.
  - No match and steps==MAX_STEPS: timeout<=1, cycle_len<=0, done<=1, busy<=0; go to DONE.
  - Otherwise: shift cur_state into entry 1 (entries move up by one, the oldest is dropped), cur_state<=next_state, steps<=steps+1.
- Latency: if start is accepted at edge E0, a detection with final steps=s occurs at edge E0+s+1. A timeout occurs at edge E0+MAX_STEPS+1.
- Cycles longer than HIST_DEPTH are not detected and end in timeout. This is intended.
- Exactly one of is_fixed, is_cycle, timeout is 1 while done=1. All three are 0 otherwise.
- HIST_DEPTH=1 degenerates to a fixed-point-only checker; is_cycle is then never set.
- Outputs hold in DONE indefinitely. cur_state holds the last state reached (a state on the attractor when one is detected).

Test Plan:
- Identity network (next=cur), seed 8'h5A, start pulse -> at E0+1: done=1, is_fixed=1, cycle_len=1, steps=0, cur_state=8'h5A.
- Inverter network (next=~cur), seed 8'h0F -> at E0+2: is_cycle=1, cycle_len=2, steps=1, cur_state=8'hF0.
- Shift-right network (next=cur>>1), seed 8'hF0 -> transient F0,78,3C,1E,0F,07,03,01,00, then at E0+9: is_fixed=1, cycle_len=1, steps=8, cur_state=8'h00.
- Rotate-left network, seed 8'h01: with HIST_DEPTH=8 -> is_cycle=1, cycle_len=8, steps=7. With HIST_DEPTH=4 -> timeout=1, cycle_len=0, steps=64 at E0+65.
- Increment network (next=cur+1), seed 0: pulse start again at E0+5 -> ignored, busy stays 1. Assert reset at E0+10 -> on that edge all outputs 0, state IDLE. A new start with identity network -> normal fixed-point result.
- From DONE, start with seed 8'hAA on identity network -> done drops for exactly one cycle, then done=1, is_fixed=1, steps=0. No stale valid history entries affect the result.

Source files
------------

// File: rtl/attractor_finder.sv
// attractor_finder: autonomous attractor search over an external Boolean
// gene network. From a seed it steps cur_state <= next_state, keeping the
// last HIST_DEPTH states (entry 0 = cur_state), and ends in one of three
// outcomes: fixed point, cycle (length 2..HIST_DEPTH) or timeout.
//
// Handshake: start is a request that is accepted on any rising edge where
// the block is not busy (state IDLE or DONE); it is ignored while busy=1.
// done is a level that stays high until the next accepted start or reset.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start, seed  search request and its initial state
//   next_state   combinational network output for cur_state
//   cur_state    registered current state (network input)
//   busy, done   search running / search finished (level)
//   is_fixed, is_cycle, timeout  one-hot outcome while done=1
//   cycle_len    attractor period (1 = fixed point, 0 = timeout)
//   steps        transitions taken since the seed
module attractor_finder #(
  parameter int WIDTH      = 8,
  parameter int HIST_DEPTH = 8,
  parameter int MAX_STEPS  = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  seed,
  input  logic [WIDTH-1:0]                  next_state,
  output logic [WIDTH-1:0]                  cur_state,
  output logic                              busy,
  output logic                              done,
  output logic                              is_fixed,
  output logic                              is_cycle,
  output logic                              timeout,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   cycle_len,
  output logic [$clog2(MAX_STEPS+1)-1:0]    steps
);

  localparam int CLW = $clog2(HIST_DEPTH+1);
  localparam int SW  = $clog2(MAX_STEPS+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // hist_q[0] is the current state; hist_q[1..] are older states, newest
  // first. vld_q[0] is set on every accepted start so entry 0 always takes
  // part in the comparison during RUN.
  logic [WIDTH-1:0]      hist_q [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] vld_q;

  logic           hit;
  logic [CLW-1:0] hit_len;
  logic           accept, advance, finish_hit, finish_to;

  assign cur_state = hist_q[0];

  // Scan from the oldest entry down so the smallest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_len = '0;
    for (int k = HIST_DEPTH-1; k >= 0; k--) begin
      if (vld_q[k] && (hist_q[k] == next_state)) begin
        hit     = 1'b1;
        hit_len = CLW'(k + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    advance    = 1'b0;
    finish_hit = 1'b0;
    finish_to  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (hit) begin
          finish_hit = 1'b1;
          state_d    = S_DONE;
        end else if (steps == SW'(MAX_STEPS)) begin
          finish_to = 1'b1;
          state_d   = S_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
      vld_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      is_fixed  <= 1'b0;
      is_cycle  <= 1'b0;
      timeout   <= 1'b0;
      cycle_len <= '0;
      steps     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hist_q[0] <= seed;
        vld_q     <= HIST_DEPTH'(1);
        steps     <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
        is_fixed  <= 1'b0;
        is_cycle  <= 1'b0;
        timeout   <= 1'b0;
        cycle_len <= '0;
      end
      if (finish_hit) begin
        cycle_len <= hit_len;
        is_fixed  <= (hit_len == CLW'(1));
        is_cycle  <= (hit_len != CLW'(1));
        done      <= 1'b1;
        busy      <= 1'b0;
      end
      if (finish_to) begin
        timeout   <= 1'b1;
        cycle_len <= '0;
        done      <= 1'b1;
        busy      <= 1'b0;
      end
      if (advance) begin
        for (int k = HIST_DEPTH-1; k >= 1; k--) begin
          hist_q[k] <= hist_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
        hist_q[0] <= next_state;
        steps     <= steps + 1'b1;
      end
    end
  end

endmodule
